pwr_seq_ctrl: RTL
=================

// Module: pwr_seq_ctrl
// PURPOSE
//  Sequencer for one switchable power domain (e.g. VDD or VDDA island under TOP).
//  Drives power switch, isolation, retention save/restore and domain reset
//  in the legal order on request, with switch-ack handshake and timeout.
//  One instance per switchable domain; sits in the always-on domain.
// PARAMETERS
//  ISO_CYC   2    cycles isolation held asserted before retention save
//  RET_CYC   3    width (cycles) of ret_save / ret_restore pulses
//  RST_CYC   4    cycles domain reset held after switch ack, before release
//  TO_CYC    16   max cycles to wait for sw_ack before timeout error
// PORTS
//  clk          in   1  clock (always-on)
//  rst_n        in   1  async active-low reset
//  pwr_req      in   1  level: 1 = domain should be on, 0 = off
//  sw_ack       in   1  power switch chain ack (1 = domain supply up)
//  err_clr      in   1  pulse: clears err_timeout
//  pwr_sw_en    out  1  power switch enable (1 = supply on)
//  iso_en       out  1  isolation clamp enable for domain outputs
//  ret_save     out  1  retention save strobe
//  ret_restore  out  1  retention restore strobe
//  dom_rst_n    out  1  domain reset, active low
//  pwr_on       out  1  status: domain fully on (state ON)
//  busy         out  1  sequence in progress (not OFF/ON)
//  err_timeout  out  1  sticky: sw_ack timeout occurred
// BEHAVIOUR
//  Reset (async, rst_n=0): state OFF, ret_valid=0, err_timeout=0; outputs
//   pwr_sw_en=0 iso_en=1 ret_save=0 ret_restore=0 dom_rst_n=0 pwr_on=0 busy=0.
//  Outputs are decoded from registered state only; no comb path input->output.
//  States / outputs (sw_en,iso,save,restore,rst_n):
//   OFF(0,1,0,0,0) PU_SW(1,1,0,0,0) PU_RST(1,1,0,0,0) PU_RES(1,1,0,1,1)
//   ON(1,0,0,0,1) PD_ISO(1,1,0,0,1) PD_SAVE(1,1,1,0,1) PD_RST(1,1,0,0,0)
//   PD_SW(0,1,0,0,0)
//  Transitions (one down-counter cnt, width $clog2 of max param +1):
//   OFF: pwr_req=1 -> PU_SW, cnt=TO_CYC-1.
//   PU_SW: sw_ack=1 -> PU_RST, cnt=RST_CYC-1; else cnt==0 -> OFF, set err.
//   PU_RST: cnt==0 -> (ret_valid ? PU_RES, cnt=RET_CYC-1 : ON).
//   PU_RES: cnt==0 -> ON.
//   ON: pwr_req=0 -> PD_ISO, cnt=ISO_CYC-1.
//   PD_ISO: cnt==0 -> PD_SAVE, cnt=RET_CYC-1.
//   PD_SAVE: cnt==0 -> PD_RST, set ret_valid.
//   PD_RST: 1 cycle -> PD_SW, cnt=TO_CYC-1.
//   PD_SW: sw_ack=0 -> OFF; else cnt==0 -> OFF, set err (switch forced off).
//  pwr_req sampled only in OFF and ON; sequences are atomic, request changes
//   mid-sequence are acted on after reaching OFF/ON (next cycle).
//  First power-up after reset skips PU_RES (ret_valid=0).
//  err_timeout: set on timeout, held until err_clr; set wins if same cycle.
//   Error does not block new requests.
//  busy = state not in {OFF, ON}; pwr_on = (state==ON).
//  Reset mid-sequence: immediate return to OFF values; ret_valid lost.
// TESTING
//  1 rst_n low then high, pwr_req=1, sw_ack follows pwr_sw_en after 3 cyc ->
//    pwr_sw_en rises 1 cyc after req, dom_rst_n high 4 cyc after ack, no
//    ret_restore pulse, pwr_on=1, iso_en=0.
//  2 From ON, pwr_req=0 -> iso_en=1 for 2 cyc, ret_save high exactly 3 cyc,
//    dom_rst_n low, then pwr_sw_en=0; sw_ack drop -> OFF, busy=0.
//  3 Power up again -> ret_restore high exactly 3 cyc with dom_rst_n=1,
//    iso_en=1, then ON with iso_en=0.
//  4 pwr_req=1, sw_ack held 0 -> after 16 cyc in PU_SW: pwr_sw_en=0,
//    err_timeout=1, state OFF; err_clr pulse -> err_timeout=0.
//  5 pwr_req toggled 1->0 during PU_RST -> up sequence completes to ON
//    (pwr_on 1 cyc), then power-down starts next cycle.
//  6 rst_n asserted during PD_SAVE -> all outputs at reset values same cycle;
//    next power-up has no ret_restore pulse.

Source files
------------

// File: rtl/pwr_seq_ctrl.sv
// Power sequencer for one switchable domain: drives switch, isolation, retention
// and domain reset in legal order, with switch-ack handshake and timeout.
module pwr_seq_ctrl #(
  parameter int unsigned ISO_CYC = 2,
  parameter int unsigned RET_CYC = 3,
  parameter int unsigned RST_CYC = 4,
  parameter int unsigned TO_CYC  = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pwr_req,
  input  logic sw_ack,
  input  logic err_clr,
  output logic pwr_sw_en,
  output logic iso_en,
  output logic ret_save,
  output logic ret_restore,
  output logic dom_rst_n,
  output logic pwr_on,
  output logic busy,
  output logic err_timeout
);

  localparam int unsigned Max1   = (ISO_CYC > RET_CYC) ? ISO_CYC : RET_CYC;
  localparam int unsigned Max2   = (RST_CYC > TO_CYC) ? RST_CYC : TO_CYC;
  localparam int unsigned MaxCyc = (Max1 > Max2) ? Max1 : Max2;
  localparam int unsigned CntW   = $clog2(MaxCyc + 1);

  typedef logic [CntW-1:0] cnt_t;

  localparam cnt_t IsoLd = cnt_t'(ISO_CYC - 1);
  localparam cnt_t RetLd = cnt_t'(RET_CYC - 1);
  localparam cnt_t RstLd = cnt_t'(RST_CYC - 1);
  localparam cnt_t ToLd  = cnt_t'(TO_CYC - 1);

  typedef enum logic [3:0] {
    StOff,
    StPuSw,
    StPuRst,
    StPuRes,
    StOn,
    StPdIso,
    StPdSave,
    StPdRst,
    StPdSw
  } state_e;

  state_e state_q, state_d;
  cnt_t   cnt_q, cnt_d;
  logic   ret_valid_q, ret_valid_d;
  logic   err_q, err_d;
  logic   err_set;
  logic   cnt_zero;
  cnt_t   cnt_dec;

  assign cnt_zero = (cnt_q == '0);
  assign cnt_dec  = cnt_q - cnt_t'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StOff;
      cnt_q       <= '0;
      ret_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ret_valid_q <= ret_valid_d;
      err_q       <= err_d;
    end
  end

  // pwr_req is only looked at in StOff/StOn so every sequence runs to completion.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    ret_valid_d = ret_valid_q;
    err_set     = 1'b0;
    unique case (state_q)
      StOff: begin
        if (pwr_req) begin
          state_d = StPuSw;
          cnt_d   = ToLd;
        end
      end
      StPuSw: begin
        if (sw_ack) begin
          state_d = StPuRst;
          cnt_d   = RstLd;
        end else if (cnt_zero) begin
          state_d = StOff;
          err_set = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      StPuRst: begin
        if (cnt_zero) begin
          if (ret_valid_q) begin
            state_d = StPuRes;
            cnt_d   = RetLd;
          end else begin
            state_d = StOn;
          end
        end else begin
          cnt_d = cnt_dec;
        end
      end
      StPuRes: begin
        if (cnt_zero) state_d = StOn;
        else          cnt_d   = cnt_dec;
      end
      StOn: begin
        if (!pwr_req) begin
          state_d = StPdIso;
          cnt_d   = IsoLd;
        end
      end
      StPdIso: begin
        if (cnt_zero) begin
          state_d = StPdSave;
          cnt_d   = RetLd;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      StPdSave: begin
        if (cnt_zero) begin
          state_d     = StPdRst;
          ret_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      StPdRst: begin
        state_d = StPdSw;
        cnt_d   = ToLd;
      end
      StPdSw: begin
        // A stuck ack still ends in OFF; the switch is forced off regardless.
        if (!sw_ack) begin
          state_d = StOff;
        end else if (cnt_zero) begin
          state_d = StOff;
          err_set = 1'b1;
        end else begin
          cnt_d = cnt_dec;
        end
      end
      default: state_d = StOff;
    endcase
  end

  assign err_d = err_set | (err_q & ~err_clr);

  always_comb begin
    pwr_sw_en   = 1'b0;
    iso_en      = 1'b1;
    ret_save    = 1'b0;
    ret_restore = 1'b0;
    dom_rst_n   = 1'b0;
    unique case (state_q)
      StPuSw, StPuRst, StPdRst: pwr_sw_en = 1'b1;
      StPuRes: begin
        pwr_sw_en   = 1'b1;
        ret_restore = 1'b1;
        dom_rst_n   = 1'b1;
      end
      StOn: begin
        pwr_sw_en = 1'b1;
        iso_en    = 1'b0;
        dom_rst_n = 1'b1;
      end
      StPdIso: begin
        pwr_sw_en = 1'b1;
        dom_rst_n = 1'b1;
      end
      StPdSave: begin
        pwr_sw_en = 1'b1;
        ret_save  = 1'b1;
        dom_rst_n = 1'b1;
      end
      default: ;
    endcase
  end

  assign pwr_on      = (state_q == StOn);
  assign busy        = (state_q != StOff) && (state_q != StOn);
  assign err_timeout = err_q;

endmodule
